// File: rtl/cache_arbiter.sv
// cache_arbiter: shares one line-wide lower memory port between the I-L1 and D-L1.
// Ports: clk/rst; inst_* (read-only I side), data_* (read/write D side), pmem_* (shared memory).
module cache_arbiter #(
    parameter int ADDR_W = 32,
    parameter int LINE_W = 256
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] inst_address,
    input  logic              inst_read,
    output logic [LINE_W-1:0] inst_rdata,
    output logic              inst_resp,
    input  logic [ADDR_W-1:0] data_address,
    input  logic [LINE_W-1:0] data_wdata,
    input  logic              data_read,
    input  logic              data_write,
    output logic [LINE_W-1:0] data_rdata,
    output logic              data_resp,
    output logic [ADDR_W-1:0] pmem_address,
    output logic [LINE_W-1:0] pmem_wdata,
    output logic              pmem_read,
    output logic              pmem_write,
    input  logic [LINE_W-1:0] pmem_rdata,
    input  logic              pmem_resp
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SERVE_I = 2'd1,
        SERVE_D = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic                last_d_q, last_d_d;
    logic [ADDR_W-1:0]   cmd_addr_q, cmd_addr_d;
    logic [LINE_W-1:0]   cmd_wdata_q, cmd_wdata_d;
    logic                cmd_read_q, cmd_read_d;
    logic                cmd_write_q, cmd_write_d;

    logic req_i, req_d;
    logic grant_i, grant_d;

    assign req_i = inst_read;
    assign req_d = data_read | data_write;

    // On a tie, D wins unless D was the last side served.
    assign grant_d = req_d & (~req_i | ~last_d_q);
    assign grant_i = req_i & ~grant_d;

    always_comb begin
        state_d     = state_q;
        last_d_d    = last_d_q;
        cmd_addr_d  = cmd_addr_q;
        cmd_wdata_d = cmd_wdata_q;
        cmd_read_d  = cmd_read_q;
        cmd_write_d = cmd_write_q;
        unique case (state_q)
            IDLE: begin
                if (grant_d) begin
                    state_d     = SERVE_D;
                    last_d_d    = 1'b1;
                    cmd_addr_d  = data_address;
                    cmd_wdata_d = data_wdata;
                    cmd_write_d = data_write;
                    cmd_read_d  = ~data_write;
                end else if (grant_i) begin
                    state_d     = SERVE_I;
                    last_d_d    = 1'b0;
                    cmd_addr_d  = inst_address;
                    cmd_wdata_d = '0;
                    cmd_write_d = 1'b0;
                    cmd_read_d  = 1'b1;
                end
            end
            SERVE_I, SERVE_D: begin
                if (pmem_resp) begin
                    // Address and data are cleared too so the
                    // pmem bus reads all-zero whenever idle.
                    state_d     = IDLE;
                    cmd_addr_d  = '0;
                    cmd_wdata_d = '0;
                    cmd_read_d  = 1'b0;
                    cmd_write_d = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            last_d_q    <= 1'b0;
            cmd_addr_q  <= '0;
            cmd_wdata_q <= '0;
            cmd_read_q  <= 1'b0;
            cmd_write_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            last_d_q    <= last_d_d;
            cmd_addr_q  <= cmd_addr_d;
            cmd_wdata_q <= cmd_wdata_d;
            cmd_read_q  <= cmd_read_d;
            cmd_write_q <= cmd_write_d;
        end
    end

    assign pmem_address = cmd_addr_q;
    assign pmem_wdata   = cmd_wdata_q;
    assign pmem_read    = cmd_read_q;
    assign pmem_write   = cmd_write_q;

    assign inst_rdata = pmem_rdata;
    assign data_rdata = pmem_rdata;
    assign inst_resp  = (state_q == SERVE_I) & pmem_resp;
    assign data_resp  = (state_q == SERVE_D) & pmem_resp;

endmodule

// File: tb/tb_cache_arbiter.sv
// tb_cache_arbiter: cycle-by-cycle directed vectors for cache_arbiter.
// Inputs driven at negedge, outputs checked 1ns later.
module tb_cache_arbiter;

    localparam int AW = 32;
    localparam int LW = 256;

    logic          clk = 1'b0;
    logic          rst;
    logic [AW-1:0] inst_address;
    logic          inst_read;
    logic [LW-1:0] inst_rdata;
    logic          inst_resp;
    logic [AW-1:0] data_address;
    logic [LW-1:0] data_wdata;
    logic          data_read;
    logic          data_write;
    logic [LW-1:0] data_rdata;
    logic          data_resp;
    logic [AW-1:0] pmem_address;
    logic [LW-1:0] pmem_wdata;
    logic          pmem_read;
    logic          pmem_write;
    logic [LW-1:0] pmem_rdata;
    logic          pmem_resp;

    cache_arbiter #(.ADDR_W(AW), .LINE_W(LW)) dut (
        .clk          (clk),
        .rst          (rst),
        .inst_address (inst_address),
        .inst_read    (inst_read),
        .inst_rdata   (inst_rdata),
        .inst_resp    (inst_resp),
        .data_address (data_address),
        .data_wdata   (data_wdata),
        .data_read    (data_read),
        .data_write   (data_write),
        .data_rdata   (data_rdata),
        .data_resp    (data_resp),
        .pmem_address (pmem_address),
        .pmem_wdata   (pmem_wdata),
        .pmem_read    (pmem_read),
        .pmem_write   (pmem_write),
        .pmem_rdata   (pmem_rdata),
        .pmem_resp    (pmem_resp)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic          rst;
        logic          ir;
        logic [AW-1:0] ia;
        logic          dr;
        logic          dw;
        logic [AW-1:0] da;
        logic [LW-1:0] dwd;
        logic          presp;
        logic [LW-1:0] prd;
        logic          e_rd;
        logic          e_wr;
        logic [AW-1:0] e_addr;
        logic [LW-1:0] e_wd;
        logic          e_ir;
        logic          e_dr;
    } vec_t;

    vec_t vq[$];
    int   checks = 0;
    int   errors = 0;

    localparam logic [LW-1:0] A5 = {8{32'hA5A5_A5A5}};
    localparam logic [LW-1:0] W1 = {8{32'h1234_5678}};
    localparam logic [LW-1:0] W2 = {8{32'hDEAD_BEEF}};
    localparam logic [LW-1:0] Z  = '0;

    task automatic add(
        input logic r, input logic ir, input logic [AW-1:0] ia,
        input logic dr, input logic dw, input logic [AW-1:0] da,
        input logic [LW-1:0] dwd, input logic ps, input logic [LW-1:0] prd,
        input logic erd, input logic ewr, input logic [AW-1:0] ea,
        input logic [LW-1:0] ewd, input logic eir, input logic edr);
        vec_t v;
        v.rst = r; v.ir = ir; v.ia = ia; v.dr = dr; v.dw = dw;
        v.da = da; v.dwd = dwd; v.presp = ps; v.prd = prd;
        v.e_rd = erd; v.e_wr = ewr; v.e_addr = ea; v.e_wd = ewd;
        v.e_ir = eir; v.e_dr = edr;
        vq.push_back(v);
    endtask

    task automatic chk1(input string n, input int row, input logic a, input logic e);
        checks++;
        if (a !== e) begin
            errors++;
            $display("FAIL %s row %0d: got %b expected %b", n, row, a, e);
        end
    endtask

    task automatic chkw(input string n, input int row, input logic [LW-1:0] a, input logic [LW-1:0] e);
        checks++;
        if (a !== e) begin
            errors++;
            $display("FAIL %s row %0d: got %h expected %h", n, row, a, e);
        end
    endtask

    task automatic drive(input vec_t v);
        rst = v.rst; inst_read = v.ir; inst_address = v.ia;
        data_read = v.dr; data_write = v.dw; data_address = v.da;
        data_wdata = v.dwd; pmem_resp = v.presp; pmem_rdata = v.prd;
    endtask

    initial begin
        int waited;
        rst = 1'b1; inst_read = 1'b0; inst_address = '0;
        data_read = 1'b0; data_write = 1'b0; data_address = '0;
        data_wdata = '0; pmem_resp = 1'b0; pmem_rdata = '0;

        // rst ir ia | dr dw da dwd | ps prd || rd wr addr wd ir dr
        add(0,0,0, 0,0,0,Z, 0,Z,  0,0,0,Z,0,0);
        // solo I read, resp 5 cycles after pmem_read
        add(0,1,32'h40, 0,0,0,Z, 0,Z,  0,0,0,Z,0,0);
        for (int k = 0; k < 5; k++)
            add(0,1,32'h40, 0,0,0,Z, 0,Z,  1,0,32'h40,Z,0,0);
        add(0,0,32'h40, 0,0,0,Z, 1,A5,  1,0,32'h40,Z,1,0);
        add(0,0,0, 0,0,0,Z, 0,Z,  0,0,0,Z,0,0);
        // D writeback, request dropped and wdata changed after grant
        add(0,0,0, 0,1,32'h8000_0100,W1, 0,Z,  0,0,0,Z,0,0);
        add(0,0,0, 0,0,32'h8000_0100,W2, 0,Z,  0,1,32'h8000_0100,W1,0,0);
        add(0,0,0, 0,0,0,W2, 0,Z,  0,1,32'h8000_0100,W1,0,0);
        add(0,0,0, 0,0,0,Z, 1,A5,  0,1,32'h8000_0100,W1,0,1);
        add(0,0,0, 0,0,0,Z, 0,Z,  0,0,0,Z,0,0);
        // reset, then four back-to-back ties: D, I, D, I
        add(1,0,0, 0,0,0,Z, 0,Z,  0,0,0,Z,0,0);
        add(0,1,32'h100, 1,0,32'h200,W2, 0,Z,  0,0,0,Z,0,0);
        add(0,1,32'h100, 1,0,32'h200,W2, 1,W1,  1,0,32'h200,W2,0,1);
        add(0,1,32'h100, 1,0,32'h200,W2, 0,Z,  0,0,0,Z,0,0);
        add(0,1,32'h100, 1,0,32'h200,W2, 1,A5,  1,0,32'h100,Z,1,0);
        add(0,1,32'h100, 1,0,32'h200,W2, 0,Z,  0,0,0,Z,0,0);
        add(0,1,32'h100, 1,0,32'h200,W2, 1,W2,  1,0,32'h200,W2,0,1);
        add(0,1,32'h100, 1,0,32'h200,W2, 0,Z,  0,0,0,Z,0,0);
        add(0,0,32'h100, 0,0,32'h200,W2, 1,A5,  1,0,32'h100,Z,1,0);
        // reset mid-transaction, late resp ignored, next tie to D
        add(0,0,0, 1,0,32'h300,Z, 0,Z,  0,0,0,Z,0,0);
        add(1,0,0, 0,0,0,Z, 0,Z,  1,0,32'h300,Z,0,0);
        add(0,0,0, 0,0,0,Z, 0,Z,  0,0,0,Z,0,0);
        add(0,0,0, 0,0,0,Z, 1,A5,  0,0,0,Z,0,0);
        add(0,1,32'h100, 1,0,32'h200,Z, 0,Z,  0,0,0,Z,0,0);
        add(0,0,0, 0,0,0,Z, 1,W1,  1,0,32'h200,Z,0,1);
        add(0,0,0, 0,0,0,Z, 0,Z,  0,0,0,Z,0,0);
        // illegal read+write: write wins
        add(0,0,0, 1,1,32'h400,W1, 0,Z,  0,0,0,Z,0,0);
        add(0,0,0, 0,0,0,Z, 0,Z,  0,1,32'h400,W1,0,0);
        add(0,0,0, 0,0,0,Z, 1,A5,  0,1,32'h400,W1,0,1);
        add(0,0,0, 0,0,0,Z, 0,Z,  0,0,0,Z,0,0);
        // spurious resp in IDLE, then normal I grant
        add(0,0,0, 0,0,0,Z, 1,A5,  0,0,0,Z,0,0);
        add(0,1,32'h40, 0,0,0,Z, 0,Z,  0,0,0,Z,0,0);
        add(0,0,0, 0,0,0,Z, 1,W2,  1,0,32'h40,Z,1,0);
        add(0,0,0, 0,0,0,Z, 0,Z,  0,0,0,Z,0,0);

        repeat (2) @(posedge clk);
        for (int i = 0; i < vq.size(); i++) begin
            @(negedge clk);
            drive(vq[i]);
            #1;
            chk1("pmem_read", i, pmem_read, vq[i].e_rd);
            chk1("pmem_write", i, pmem_write, vq[i].e_wr);
            chkw("pmem_address", i, {{(LW-AW){1'b0}}, pmem_address}, {{(LW-AW){1'b0}}, vq[i].e_addr});
            chkw("pmem_wdata", i, pmem_wdata, vq[i].e_wd);
            chk1("inst_resp", i, inst_resp, vq[i].e_ir);
            chk1("data_resp", i, data_resp, vq[i].e_dr);
            if (vq[i].e_ir) chkw("inst_rdata", i, inst_rdata, vq[i].prd);
            if (vq[i].e_dr) chkw("data_rdata", i, data_rdata, vq[i].prd);
        end

        // D waits through an I transaction, then is served next
        @(negedge clk);
        inst_read = 1'b1; inst_address = 32'h600;
        #1;
        @(negedge clk);
        data_read = 1'b1; data_address = 32'h500;
        pmem_resp = 1'b1; pmem_rdata = W1;
        #1;
        chk1("seq_inst_resp", 0, inst_resp, 1'b1);
        chk1("seq_data_resp", 0, data_resp, 1'b0);
        @(negedge clk);
        pmem_resp = 1'b0;
        waited = 0;
        #1;
        while (!pmem_read && waited < 8) begin
            @(negedge clk);
            #1;
            waited++;
        end
        checks++;
        if (!pmem_read) begin
            errors++;
            $display("FAIL seq_timeout: no pmem_read within %0d cycles, expected grant", waited);
        end
        chkw("seq_addr", 1, {{(LW-AW){1'b0}}, pmem_address}, {{(LW-AW){1'b0}}, 32'h500});
        @(negedge clk);
        data_read = 1'b0; inst_read = 1'b0;
        pmem_resp = 1'b1; pmem_rdata = A5;
        #1;
        chk1("seq_data_resp", 1, data_resp, 1'b1);
        chk1("seq_inst_resp", 1, inst_resp, 1'b0);
        chkw("seq_data_rdata", 1, data_rdata, A5);
        @(negedge clk);
        pmem_resp = 1'b0;
        #1;
        chk1("seq_idle_read", 2, pmem_read, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/cache_arbiter.md
Name: cache_arbiter

Overview:
- Shares one line-granular lower-level memory port (L2 or physical memory) between the instruction L1 and the data L1.
- Each L1's pmem_* side connects to this block's inst_* or data_* port; the pmem_* side drives the shared memory.
- Grants one requester at a time through a 3-state FSM.
- Latches the granted command so the downstream request stays stable until pmem_resp.
- Resolves simultaneous requests round-robin.

Parameters:
- ADDR_W, 32, address width in bits (rv32i_word)
- LINE_W, 256, cache line width in bits (rv32i_cache_line)

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- inst_address  in  ADDR_W  I-cache line address
- inst_read  in  1  I-cache line read request (I side is read-only)
- inst_rdata  out  LINE_W  line returned to I-cache
- inst_resp  out  1  I-cache transaction complete
- data_address  in  ADDR_W  D-cache line address
- data_wdata  in  LINE_W  writeback line from D-cache
- data_read  in  1  D-cache line read request
- data_write  in  1  D-cache line writeback request
- data_rdata  out  LINE_W  line returned to D-cache
- data_resp  out  1  D-cache transaction complete
- pmem_address  out  ADDR_W  latched address to lower memory
- pmem_wdata  out  LINE_W  latched write line to lower memory
- pmem_read  out  1  latched read command
- pmem_write  out  1  latched write command
- pmem_rdata  in  LINE_W  line from lower memory
- pmem_resp  in  1  lower memory transaction complete

Behaviour:
- FSM states: IDLE, SERVE_I, SERVE_D. Registers: state, last_grant (I/D), cmd_addr, cmd_wdata, cmd_read, cmd_write.
- Reset (rst high at an edge, any state, including mid-transaction):
  - state to IDLE, last_grant to I, all cmd_* to 0.
  - Any in-flight transaction is abandoned; a late pmem_resp arriving in IDLE is ignored.
- Request terms: req_i = inst_read; req_d = data_read | data_write.
- Transitions from IDLE:
  - req_i only: go to SERVE_I.
  - req_d only: go to SERVE_D.
  - Both: grant the side not equal to last_grant. The first tie after reset goes to D.
  - Neither: stay in IDLE.
- On grant (the IDLE edge that enters SERVE_x):
  - Latch the requester's address into cmd_addr.
  - cmd_wdata gets data_wdata for D, 0 for I.
  - SERVE_I: cmd_read=1, cmd_write=0.
  - SERVE_D: if data_write then cmd_write=1, cmd_read=0; otherwise cmd_read=1, cmd_write=0. Write wins if data_read and data_write are both high (illegal input, defined anyway).
  - Update last_grant to the granted side.
- pmem_address, pmem_wdata, pmem_read and pmem_write are driven directly from the cmd_* registers. In IDLE they are 0.
- SERVE_x holds until pmem_resp=1. In that cycle:
  - Assert that side's resp combinationally.
  - The pmem command remains asserted for that cycle.
  - Next edge: state to IDLE and cmd_read/cmd_write cleared.
- The requester may drop or change its request mid-transaction. The latched command is unaffected and resp is still delivered.
- inst_rdata and data_rdata are both continuously assigned from pmem_rdata. Data is valid only while the matching resp is high.
- Response gating:
  - inst_resp = (state==SERVE_I) & pmem_resp.
  - data_resp = (state==SERVE_D) & pmem_resp.
  - Never both high. Neither is ever high in IDLE.
- Latency:
  - Request seen in IDLE at cycle 0 puts the pmem command out in cycle 1.
  - Requester resp arrives in the same cycle as pmem_resp.
  - One mandatory IDLE cycle between consecutive transactions.
- A requester still asserting after a grant to the other side waits in IDLE arbitration. It is guaranteed service next, which gives no starvation.
- Reset values of all outputs: 0.

Test Plan:
- Solo I read:
  - Stimulus: inst_read=1, inst_address=0x0000_0040; memory returns pmem_resp 5 cycles after pmem_read with rdata=0xA5..A5.
  - Required: pmem_read rises 1 cycle after the request with pmem_address=0x40; inst_resp high exactly with pmem_resp; inst_rdata=0xA5..A5; data_resp stays 0.
- D writeback:
  - Stimulus: data_write=1, data_address=0x8000_0100, data_wdata=0x1234..; drop data_write and change data_wdata the cycle after the grant.
  - Required: pmem_write=1, pmem_address=0x8000_0100, and pmem_wdata=0x1234.. held unchanged until pmem_resp; then data_resp=1.
- Simultaneous requests after reset:
  - Stimulus: inst_read and data_read both high and held.
  - Required: D served first, then one IDLE cycle, then I served. Over 4 back-to-back ties, grants alternate D, I, D, I.
- Reset mid-transaction:
  - Stimulus: assert rst for 1 cycle while in SERVE_D with pmem_read=1; pmem_resp arrives 2 cycles later with no requests pending.
  - Required: pmem_read=0 the cycle after rst; no data_resp or inst_resp pulse; state IDLE; next tie grants D.
- Illegal D read+write:
  - Stimulus: data_read=1 and data_write=1 in the same cycle.
  - Required: pmem_write=1, pmem_read=0.
- Spurious pmem_resp in IDLE:
  - Stimulus: pulse pmem_resp with no requests.
  - Required: inst_resp=data_resp=0; state unchanged.
